multi_alarm_ctrl: RTL and testbench

//  Parametrised successor to the single-alarm checker. Holds NUM_ALARMS programmable BCD HH:MM

---
 rtl/multi_alarm_pkg.sv | 38 +++
 rtl/bcd_time_add.sv | 31 +++
 rtl/multi_alarm_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_alarm_pkg.sv
// Shared definitions for the multi-alarm controller.
//   HHMM_W              width of a BCD {H1,H0,M1,M0} time word
//   ST_IDLE..ST_SNOOZE  encodings of the alarm_state output
//   alarm_state_e       FSM state type built on those encodings
//   bcd_digit_ok()      single BCD digit validity
//   hhmm_ok()           full 24h HH:MM BCD validity
package multi_alarm_pkg;

    localparam int unsigned HHMM_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RINGING = 3'd1;
    localparam logic [2:0] ST_GAME    = 3'd2;
    localparam logic [2:0] ST_OFF     = 3'd3;
    localparam logic [2:0] ST_SNOOZE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StRinging = ST_RINGING,
        StGame    = ST_GAME,
        StOff     = ST_OFF,
        StSnooze  = ST_SNOOZE
    } alarm_state_e;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    function automatic logic hhmm_ok(input logic [HHMM_W-1:0] t);
        logic digits_ok;
        logic hour_ok;
        digits_ok = bcd_digit_ok(t[15:12]) && bcd_digit_ok(t[11:8]) &&
                    bcd_digit_ok(t[7:4]) && bcd_digit_ok(t[3:0]);
        hour_ok   = (t[15:12] < 4'd2) || ((t[15:12] == 4'd2) && (t[11:8] <= 4'd3));
        return digits_ok && hour_ok && (t[7:4] <= 4'd5);
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Combinational BCD HH:MM + minutes with 24h wrap (23:5x + n rolls into 00:0y).
//   time_in   BCD {H1,H0,M1,M0}, assumed valid
//   add_min   minutes to add, binary 0..59
//   time_out  BCD result
module bcd_time_add
    import multi_alarm_pkg::*;
(
    input  logic [HHMM_W-1:0] time_in,
    input  logic [5:0]        add_min,
    output logic [HHMM_W-1:0] time_out
);

    logic [6:0] min_sum;
    logic [4:0] hr_sum;
    logic       carry;

    always_comb begin
        min_sum = 7'(time_in[7:4]) * 7'd10 + 7'(time_in[3:0]) + 7'(add_min);
        carry   = min_sum >= 7'd60;
        if (carry) begin
            min_sum = min_sum - 7'd60;
        end
        hr_sum = 5'(time_in[15:12]) * 5'd10 + 5'(time_in[11:8]) + 5'(carry);
        if (hr_sum >= 5'd24) begin
            hr_sum = 5'd0;
        end
        time_out = {4'(hr_sum / 5'd10), 4'(hr_sum % 5'd10),
                    4'(min_sum / 7'd10), 4'(min_sum % 7'd10)};
    end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel BCD HH:MM alarm controller. Each armed channel fires once when the current
// time changes onto its alarm time; fired channels queue in a pending mask and are served
// lowest index first through RINGING -> GAME -> OFF.
// Optional feature: define MULTI_ALARM_SNOOZE_EN to compile in the SNOOZE state.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   enable               0 forces IDLE and drops pending rings
//   current              current BCD time
//   wr_en/wr_idx/wr_time/wr_arm   alarm table write port
//   push_m, push_s, game_done     user / mini-game pulses
//   wr_err               pulse: rejected write
//   game_start, missed   pulses on GAME entry / ring timeout
//   ring, ring_idx       ringing indication and served channel
//   alarm_state          FSM state encoding
module multi_alarm_ctrl
    import multi_alarm_pkg::*;
#(
    parameter int unsigned NUM_ALARMS   = 4,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned RING_TIMEOUT = 6000,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic [HHMM_W-1:0]  current,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [HHMM_W-1:0]  wr_time,
    input  logic               wr_arm,
    input  logic               push_m,
    input  logic               push_s,
    input  logic               game_done,
    output logic               wr_err,
    output logic               game_start,
    output logic               ring,
    output logic [IDX_W-1:0]   ring_idx,
    output logic               missed,
    output logic [2:0]         alarm_state
);

    localparam int unsigned CNT_W = $clog2(RING_TIMEOUT + 1);

    alarm_state_e            state_q, state_d;
    logic [HHMM_W-1:0]       alarm_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]   armed_q, pending_q, pending_d, trig;
    logic [HHMM_W-1:0]       prev_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    game_start_q, game_start_d, missed_q, missed_d, wr_err_q;
    logic                    cur_changed, wr_ok, found;

    assign cur_changed = current != prev_q;
    assign wr_ok       = hhmm_ok(wr_time) && (32'(wr_idx) < NUM_ALARMS);

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = $clog2(MAX_SNOOZE + 1);
    logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic [HHMM_W-1:0] target_q, target_d, snooze_time;

    bcd_time_add u_snooze_add (
        .time_in  (current),
        .add_min  (6'(SNOOZE_MIN)),
        .time_out (snooze_time)
    );
`else
    logic unused_snooze;
    assign unused_snooze = push_s ^ (SNOOZE_MIN == 0) ^ (MAX_SNOOZE == 0);
`endif

    // Alarm table, write error pulse and previous-time register run regardless of enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_q[i] <= '0;
            end
            armed_q  <= '0;
            prev_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            prev_q   <= current;
            wr_err_q <= wr_en && !hhmm_ok(wr_time);
            if (wr_en && wr_ok) begin
                alarm_q[wr_idx] <= wr_time;
                armed_q[wr_idx] <= wr_arm;
            end
        end
    end

    // Edge-qualified match so a time held on an alarm value fires only once.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            trig[i] = cur_changed && armed_q[i] && (current == alarm_q[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q | trig;
        game_start_d = 1'b0;
        missed_d     = 1'b0;
        found        = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt_d    = snz_cnt_q;
        target_d     = target_q;
`endif
        if (!enable) begin
            state_d   = StIdle;
            pending_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Include this cycle's triggers so service starts one cycle after the match.
                    for (int i = 0; i < NUM_ALARMS; i++) begin
                        if (!found && pending_d[i]) begin
                            found        = 1'b1;
                            idx_d        = IDX_W'(i);
                            pending_d[i] = 1'b0;
                        end
                    end
                    if (found) begin
                        state_d = StRinging;
                        cnt_d   = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
                        snz_cnt_d = '0;
`endif
                    end
                end
                StRinging: begin
                    if (push_m) begin
                        state_d      = StGame;
                        game_start_d = 1'b1;
`ifdef MULTI_ALARM_SNOOZE_EN
                    end else if (push_s && (snz_cnt_q < SNZ_W'(MAX_SNOOZE))) begin
                        state_d  = StSnooze;
                        target_d = snooze_time;
`endif
                    end else if (cnt_q == CNT_W'(RING_TIMEOUT - 1)) begin
                        state_d  = StOff;
                        missed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGame: begin
                    if (game_done) begin
                        state_d = StOff;
                    end
                end
                StOff: begin
                    state_d = StIdle;
                end
`ifdef MULTI_ALARM_SNOOZE_EN
                StSnooze: begin
                    if (push_m) begin
                        state_d = StOff;
                    end else if (cur_changed && (current == target_q)) begin
                        state_d   = StRinging;
                        cnt_d     = '0;
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= '0;
            game_start_q <= 1'b0;
            missed_q     <= 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
            snz_cnt_q    <= '0;
            target_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            game_start_q <= game_start_d;
            missed_q     <= missed_d;
`ifdef MULTI_ALARM_SNOOZE_EN
            snz_cnt_q    <= snz_cnt_d;
            target_q     <= target_d;
`endif
        end
    end

    assign ring        = (state_q == StRinging) || (state_q == StGame);
    assign ring_idx    = idx_q;
    assign alarm_state = state_q;
    assign game_start  = game_start_q;
    assign missed      = missed_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
module tb_multi_alarm_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] current = 16'h0000;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = 2'd0;
    logic [15:0] wr_time = 16'h0000;
    logic        wr_arm = 1'b0;
    logic        push_m = 1'b0;
    logic        push_s = 1'b0;
    logic        game_done = 1'b0;
    logic        wr_err, game_start, ring, missed;
    logic [1:0]  ring_idx;
    logic [2:0]  alarm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_alarm_ctrl #(
        .NUM_ALARMS   (4),
        .IDX_W        (2),
        .RING_TIMEOUT (8),
        .SNOOZE_MIN   (5),
        .MAX_SNOOZE   (3)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .current     (current),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_time     (wr_time),
        .wr_arm      (wr_arm),
        .push_m      (push_m),
        .push_s      (push_s),
        .game_done   (game_done),
        .wr_err      (wr_err),
        .game_start  (game_start),
        .ring        (ring),
        .ring_idx    (ring_idx),
        .missed      (missed),
        .alarm_state (alarm_state)
    );

    // Status word compared in most checks: {alarm_state, ring, ring_idx}.
    wire [5:0] st = {alarm_state, ring, ring_idx};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_alarm(input logic [1:0] idx, input logic [15:0] t, input logic arm);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_time = t;
        wr_arm  = arm;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic set_time(input logic [15:0] t);
        current = t;
        tick();
    endtask

    task automatic pulse_m();
        push_m = 1'b1;
        tick();
        push_m = 1'b0;
    endtask

    task automatic pulse_done();
        game_done = 1'b1;
        tick();
        game_done = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        checks++;
        if ({st, wr_err, game_start, missed} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", {st, wr_err, game_start, missed}, 9'd0);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_alarm(2'd1, 16'h0730, 1'b1);
        checks++;
        if (wr_err !== 1'b0) begin
            errors++; $display("FAIL single_wr_ok got %b exp 0", wr_err);
        end
        set_time(16'h0729);
        set_time(16'h0730);
        checks++;
        if (st !== {3'd1, 1'b1, 2'd1}) begin
            errors++; $display("FAIL single_ring got %h exp %h", st, {3'd1, 1'b1, 2'd1});
        end
        pulse_m();
        checks++;
        if ({st, game_start} !== {3'd2, 1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_game got %h exp %h", {st, game_start}, {3'd2, 1'b1, 2'd1, 1'b1});
        end
        tick();
        checks++;
        if (game_start !== 1'b0) begin
            errors++; $display("FAIL single_gs_pulse got %b exp 0", game_start);
        end
        pulse_done();
        checks++;
        if (st !== {3'd3, 1'b0, 2'd1}) begin
            errors++; $display("FAIL single_off got %h exp %h", st, {3'd3, 1'b0, 2'd1});
        end
        tick();
        checks++;
        if (st !== {3'd0, 1'b0, 2'd1}) begin
            errors++; $display("FAIL single_idle got %h exp %h", st, {3'd0, 1'b0, 2'd1});
        end
        repeat (3) tick();
        checks++;
        if (st !== {3'd0, 1'b0, 2'd1}) begin
            errors++; $display("FAIL single_no_refire got %h exp %h", st, {3'd0, 1'b0, 2'd1});
        end
    endtask

    task automatic test_equal_and_timeout();
        write_alarm(2'd0, 16'h1200, 1'b1);
        write_alarm(2'd2, 16'h1200, 1'b1);
        set_time(16'h1159);
        set_time(16'h1200);
        checks++;
        if (st !== {3'd1, 1'b1, 2'd0}) begin
            errors++; $display("FAIL equal_ch0 got %h exp %h", st, {3'd1, 1'b1, 2'd0});
        end
        pulse_m();
        pulse_done();
        checks++;
        if (st !== {3'd3, 1'b0, 2'd0}) begin
            errors++; $display("FAIL equal_off got %h exp %h", st, {3'd3, 1'b0, 2'd0});
        end
        tick();
        checks++;
        if (st !== {3'd0, 1'b0, 2'd0}) begin
            errors++; $display("FAIL equal_idle got %h exp %h", st, {3'd0, 1'b0, 2'd0});
        end
        tick();
        checks++;
        if (st !== {3'd1, 1'b1, 2'd2}) begin
            errors++; $display("FAIL equal_ch2 got %h exp %h", st, {3'd1, 1'b1, 2'd2});
        end
        // Ring with no push: timeout of 8 cycles in RINGING.
        repeat (7) tick();
        checks++;
        if ({st, missed} !== {3'd1, 1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL timeout_early got %h exp %h", {st, missed}, {3'd1, 1'b1, 2'd2, 1'b0});
        end
        tick();
        checks++;
        if ({st, missed} !== {3'd3, 1'b0, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL timeout_missed got %h exp %h", {st, missed}, {3'd3, 1'b0, 2'd2, 1'b1});
        end
        tick();
        checks++;
        if ({st, missed} !== {3'd0, 1'b0, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL timeout_idle got %h exp %h", {st, missed}, {3'd0, 1'b0, 2'd2, 1'b0});
        end
    endtask

    task automatic test_timeout_push();
        write_alarm(2'd3, 16'h0800, 1'b1);
        set_time(16'h0759);
        set_time(16'h0800);
        checks++;
        if (st !== {3'd1, 1'b1, 2'd3}) begin
            errors++; $display("FAIL tpush_ring got %h exp %h", st, {3'd1, 1'b1, 2'd3});
        end
        repeat (7) tick();
        pulse_m();
        checks++;
        if ({st, missed, game_start} !== {3'd2, 1'b1, 2'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL tpush_game got %h exp %h", {st, missed, game_start},
                     {3'd2, 1'b1, 2'd3, 1'b0, 1'b1});
        end
        repeat (20) tick();
        pulse_m();
        checks++;
        if (st !== {3'd2, 1'b1, 2'd3}) begin
            errors++; $display("FAIL game_no_timeout got %h exp %h", st, {3'd2, 1'b1, 2'd3});
        end
        pulse_done();
        tick();
        checks++;
        if (st !== {3'd0, 1'b0, 2'd3}) begin
            errors++; $display("FAIL tpush_idle got %h exp %h", st, {3'd0, 1'b0, 2'd3});
        end
    endtask

    task automatic test_wr_err_and_reset();
        write_alarm(2'd1, 16'h2460, 1'b1);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL wr_err_2460 got %b exp 1", wr_err);
        end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++; $display("FAIL wr_err_pulse got %b exp 0", wr_err);
        end
        write_alarm(2'd1, 16'h2400, 1'b1);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL wr_err_2400 got %b exp 1", wr_err);
        end
        write_alarm(2'd1, 16'h1a00, 1'b1);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL wr_err_digit got %b exp 1", wr_err);
        end
        write_alarm(2'd0, 16'h2359, 1'b0);
        checks++;
        if (wr_err !== 1'b0) begin
            errors++; $display("FAIL wr_ok_2359 got %b exp 0", wr_err);
        end
        // ch1 must still hold 0730 armed.
        set_time(16'h0729);
        set_time(16'h0730);
        checks++;
        if (st !== {3'd1, 1'b1, 2'd1}) begin
            errors++; $display("FAIL wr_err_table got %h exp %h", st, {3'd1, 1'b1, 2'd1});
        end
        pulse_m();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({st, game_start, missed} !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", {st, game_start, missed}, 8'd0);
        end
        tick();
        resetn = 1'b1;
        set_time(16'h0729);
        set_time(16'h0730);
        tick();
        checks++;
        if (st !== 6'd0) begin
            errors++; $display("FAIL reset_disarm got %h exp %h", st, 6'd0);
        end
    endtask

    task automatic test_enable();
        write_alarm(2'd2, 16'h0900, 1'b1);
        write_alarm(2'd3, 16'h0900, 1'b1);
        set_time(16'h0859);
        set_time(16'h0900);
        checks++;
        if (st !== {3'd1, 1'b1, 2'd2}) begin
            errors++; $display("FAIL enable_ring got %h exp %h", st, {3'd1, 1'b1, 2'd2});
        end
        enable = 1'b0;
        tick();
        checks++;
        if (st !== {3'd0, 1'b0, 2'd2}) begin
            errors++; $display("FAIL enable_off got %h exp %h", st, {3'd0, 1'b0, 2'd2});
        end
        enable = 1'b1;
        repeat (3) tick();
        checks++;
        if (st !== {3'd0, 1'b0, 2'd2}) begin
            errors++; $display("FAIL enable_pending got %h exp %h", st, {3'd0, 1'b0, 2'd2});
        end
    endtask

    task automatic test_back_to_back();
        write_alarm(2'd0, 16'h1000, 1'b1);
        write_alarm(2'd1, 16'h1001, 1'b1);
        set_time(16'h0959);
        set_time(16'h1000);
        set_time(16'h1001);
        checks++;
        if (st !== {3'd1, 1'b1, 2'd0}) begin
            errors++; $display("FAIL b2b_ch0 got %h exp %h", st, {3'd1, 1'b1, 2'd0});
        end
        pulse_m();
        pulse_done();
        tick();
        tick();
        checks++;
        if (st !== {3'd1, 1'b1, 2'd1}) begin
            errors++; $display("FAIL b2b_ch1 got %h exp %h", st, {3'd1, 1'b1, 2'd1});
        end
        pulse_m();
        pulse_done();
        tick();
    endtask

`ifdef MULTI_ALARM_SNOOZE_EN
    task automatic test_snooze();
        do_reset();
        write_alarm(2'd0, 16'h2358, 1'b1);
        set_time(16'h2357);
        set_time(16'h2358);
        push_s = 1'b1;
        tick();
        push_s = 1'b0;
        checks++;
        if (st !== {3'd4, 1'b0, 2'd0}) begin
            errors++; $display("FAIL snooze_enter got %h exp %h", st, {3'd4, 1'b0, 2'd0});
        end
        set_time(16'h2359);
        set_time(16'h0000);
        set_time(16'h0002);
        checks++;
        if (st !== {3'd4, 1'b0, 2'd0}) begin
            errors++; $display("FAIL snooze_wait got %h exp %h", st, {3'd4, 1'b0, 2'd0});
        end
        set_time(16'h0003);
        checks++;
        if (st !== {3'd1, 1'b1, 2'd0}) begin
            errors++; $display("FAIL snooze_wrap got %h exp %h", st, {3'd1, 1'b1, 2'd0});
        end
        push_s = 1'b1; tick(); push_s = 1'b0;
        set_time(16'h0008);
        push_s = 1'b1; tick(); push_s = 1'b0;
        set_time(16'h0013);
        push_s = 1'b1; tick(); push_s = 1'b0;
        checks++;
        if (st !== {3'd1, 1'b1, 2'd0}) begin
            errors++; $display("FAIL snooze_limit got %h exp %h", st, {3'd1, 1'b1, 2'd0});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_equal_and_timeout();
        test_timeout_push();
        test_wr_err_and_reset();
        test_enable();
        test_back_to_back();
`ifdef MULTI_ALARM_SNOOZE_EN
        test_snooze();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
